data_mem_responder: RTL and testbench

- Word-organised data memory that acts as the responder to the core's load/store requests, i.e. the far end of mem_read/mem_write.
- Accepts one request at a time over a valid/ready handshake and waits a programmable number of cycles, modelling memory latency.
- Returns read data or write completion over a second valid/ready handshake; misaligned or out-of-range accesses return an error flag.
- Sits between the core's memory stage and the data-memory array; the core stalls on req_ready/resp_valid.

---
 rtl/data_mem_responder.sv | 157 +++++++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory responding to core load/store requests with a
// programmable access latency and an error flag for misaligned/out-of-range addresses.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, latency counter running down
// RESP  | response presented, waiting for resp_ready
module data_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [31:0] mem [0:DEPTH-1];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        mem_we;
    logic        addr_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        busy_d       = busy_q;
        mem_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d        = req_write;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    cnt_d       = CNT_LOAD;
                    state_d     = WAIT;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    // The array access shares the edge on which resp_valid rises.
                    if (addr_err) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (wr_q) begin
                        mem_we  = 1'b1;
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = mem[word_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    rdata_d      = 32'd0;
                    err_d        = 1'b0;
                    req_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    // Array contents survive reset; a reset in WAIT forces IDLE so mem_we stays low.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instances built with LATENCY 2, 1 and 15.
module tb_data_mem_responder;

    localparam int NI = 3;
    localparam int LAT [NI] = '{2, 1, 15};

    logic        clk;
    logic        reset      [NI];
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_write  [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_be     [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];
    logic        busy       [NI];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(LAT[g])) u_dut (
            .clk        (clk),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_be     (req_be[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_err   (resp_err[g]),
            .busy       (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    // Issue one request on instance i; returns accept cycle, latency, rdata, err.
    // Called #1 after a clock edge with the instance idle.
    task automatic do_req(input int i, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int acc_cyc, output int lat,
                          output logic [31:0] rdata, output logic err);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_be[i]    = be;
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid[i] = 1'b0;
        lat = 0;
        while (!resp_valid[i] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid[i]) $display("FAIL timeout inst %0d: resp_valid never rose", i);
        rdata = resp_rdata[i];
        err   = resp_err[i];
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        if (i == 0) resp_ready[i] = 1'b0;
    endtask

    int          acc, acc2, lat;
    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < NI; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_write[i] = 1'b0;
            req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_be[i] = 4'd0;
            resp_ready[i] = 1'b0;
        end
        #1;
        check("rst_req_ready",  32'(req_ready[0]),  32'd1);
        check("rst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("rst_rdata",      resp_rdata[0],      32'd0);
        check("rst_err",        32'(resp_err[0]),   32'd0);
        check("rst_busy",       32'(busy[0]),       32'd0);
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < NI; i++) reset[i] = 1'b0;
        @(posedge clk); #1;

        // Full store + readback, latency 2
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc, lat, rd, er);
        check("st10_lat",   32'(lat), 32'd2);
        check("st10_rdata", rd,       32'd0);
        check("st10_err",   32'(er),  32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, acc, lat, rd, er);
        check("ld10_lat",   32'(lat), 32'd2);
        check("ld10_rdata", rd,       32'hDEADBEEF);
        check("ld10_err",   32'(er),  32'd0);

        // Partial store
        do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, acc, lat, rd, er);
        do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, acc, lat, rd, er);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, acc, lat, rd, er);
        check("ld20_partial", rd, 32'h11BB33DD);
        do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, acc, lat, rd, er);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, acc, lat, rd, er);
        check("ld20_be0_noop", rd, 32'h11BB33DD);

        // Error cases
        do_req(0, 1'b0, 32'h12, 32'h0, 4'hF, acc, lat, rd, er);
        check("ld12_err",   32'(er), 32'd1);
        check("ld12_rdata", rd,      32'd0);
        do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, acc, lat, rd, er);
        do_req(0, 1'b1, 32'h400, 32'h55555555, 4'hF, acc, lat, rd, er);
        check("st400_err",   32'(er), 32'd1);
        check("st400_rdata", rd,      32'd0);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, acc, lat, rd, er);
        check("ld0_after_err", rd, 32'hCAFEF00D);
        check("ld0_err",       32'(er), 32'd0);

        // Backpressure: hold resp_ready low, present a competing store meanwhile
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_write[0] = 1'b1; req_wdata[0] = 32'h0BADF00D;
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(resp_valid[0]), 32'd1);
            check("bp_rdata", resp_rdata[0],      32'hDEADBEEF);
            check("bp_err",   32'(resp_err[0]),   32'd0);
            check("bp_ready", 32'(req_ready[0]),  32'd0);
            @(posedge clk); #1;
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        check("bp_rel_valid", 32'(resp_valid[0]), 32'd0);
        check("bp_rel_ready", 32'(req_ready[0]),  32'd1);
        check("bp_rel_busy",  32'(busy[0]),       32'd0);
        check("bp_rel_rdata", resp_rdata[0],      32'd0);
        @(posedge clk); #1;
        check("bp_no_accept", 32'(busy[0]), 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, acc, lat, rd, er);
        check("bp_mem_intact", rd, 32'hDEADBEEF);

        // Reset mid-WAIT discards the captured store
        do_req(0, 1'b1, 32'h30, 32'h0, 4'hF, acc, lat, rd, er);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("wait_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        reset[0] = 1'b1;
        #1;
        check("mrst_req_ready",  32'(req_ready[0]),  32'd1);
        check("mrst_resp_valid", 32'(resp_valid[0]), 32'd0);
        check("mrst_busy",       32'(busy[0]),       32'd0);
        @(posedge clk); #1;
        reset[0] = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, acc, lat, rd, er);
        check("ld30_after_rst", rd, 32'd0);

        // LATENCY 1 and 15 builds, back-to-back with resp_ready tied high
        for (int i = 1; i < NI; i++) begin
            resp_ready[i] = 1'b1;
            do_req(i, 1'b1, 32'h44, 32'h600D0000 + 32'(i), 4'hF, acc, lat, rd, er);
            check($sformatf("lat%0d_st", LAT[i]), 32'(lat), 32'(LAT[i]));
            do_req(i, 1'b0, 32'h44, 32'h0, 4'h0, acc2, lat, rd, er);
            check($sformatf("lat%0d_ld", LAT[i]), 32'(lat), 32'(LAT[i]));
            check($sformatf("lat%0d_spacing", LAT[i]), 32'(acc2 - acc), 32'(LAT[i] + 2));
            check($sformatf("lat%0d_rdata", LAT[i]), rd, 32'h600D0000 + 32'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
